// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the unified RAM port arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic [0:0] OWN_IF  = 1'b0;
    localparam logic [0:0] OWN_MEM = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Number of byte accesses a MEM request needs; size 11 is treated as a word.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_to_count = 3'd1;
            MEM_SIZE_H: size_to_count = 3'd2;
            default:    size_to_count = 3'd4;
        endcase
    endfunction

    // Little-endian byte insert into a 32-bit word.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = data;
        put_byte = w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial arbiter sharing one RAM port between IF and MEM
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RAM_ADDR_W = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    input  logic                  if_abort_i,
    output logic                  if_done_o,
    output logic [31:0]           if_inst_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_done_o,
    output logic [31:0]           mem_rdata_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    logic [0:0]            state_q;
    logic [0:0]            owner_q;
    logic                  we_q;
    logic [2:0]            n_q;
    logic [2:0]            cnt_q;
    logic [RAM_ADDR_W-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           result_q;

    logic        busy;
    logic        in_range;
    logic        done_any;
    logic        accept_mem;
    logic        accept_if;
    logic        abort_now;
    logic        last_read;
    logic        last_write;
    logic        capture;
    logic [1:0]  rd_byte_idx;
    logic [31:0] result_next;
    logic [7:0]  wr_byte;

    // The RAM only sees the low address bits; the upper request bits are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr_i[ADDR_W-1:RAM_ADDR_W], mem_addr_i[ADDR_W-1:RAM_ADDR_W]};

    assign busy     = (state_q == ARB_BUSY);
    assign in_range = busy && (cnt_q < n_q);
    // A done pulse blocks acceptance for one cycle so the requester can drop req.
    assign done_any   = if_done_o | mem_done_o;
    assign accept_mem = !busy && !done_any && mem_req_i;
    assign accept_if  = !busy && !done_any && !mem_req_i && if_req_i && !if_abort_i;
    assign abort_now  = busy && (owner_q == OWN_IF) && if_abort_i;
    // Reads need one extra cycle because RAM data lags the address by a cycle.
    assign last_read  = busy && !we_q && (cnt_q == n_q);
    assign last_write = busy && we_q && (cnt_q == n_q - 3'd1);
    assign capture    = busy && !we_q && (cnt_q != 3'd0) && !abort_now;

    assign rd_byte_idx = cnt_q[1:0] - 2'd1;
    assign result_next = put_byte(result_q, rd_byte_idx, ram_din_i);
    assign wr_byte     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

    assign ram_addr_o = in_range ? (base_q + RAM_ADDR_W'(cnt_q)) : '0;
    assign ram_wr_o   = in_range && we_q;
    assign ram_dout_o = (in_range && we_q) ? wr_byte : 8'h00;

    // Request acceptance, byte sequencing and return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            n_q     <= 3'd0;
            cnt_q   <= 3'd0;
            base_q  <= '0;
            wdata_q <= ZERO_WORD;
        end else if (!busy) begin
            if (accept_mem) begin
                state_q <= ARB_BUSY;
                owner_q <= OWN_MEM;
                we_q    <= mem_we_i;
                n_q     <= size_to_count(mem_size_i);
                cnt_q   <= 3'd0;
                base_q  <= mem_addr_i[RAM_ADDR_W-1:0];
                wdata_q <= mem_wdata_i;
            end else if (accept_if) begin
                state_q <= ARB_BUSY;
                owner_q <= OWN_IF;
                we_q    <= 1'b0;
                n_q     <= 3'd4;
                cnt_q   <= 3'd0;
                base_q  <= if_addr_i[RAM_ADDR_W-1:0];
                wdata_q <= ZERO_WORD;
            end
        end else if (abort_now || last_read || last_write) begin
            state_q <= ARB_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Read-byte assembly, result hand-off to the owner and the one-cycle done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= ZERO_WORD;
            if_inst_o   <= ZERO_WORD;
            mem_rdata_o <= ZERO_WORD;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            if (accept_mem || accept_if) begin
                result_q <= ZERO_WORD;
            end else if (capture) begin
                result_q <= result_next;
            end
            if (last_read && !abort_now) begin
                if (owner_q == OWN_IF) begin
                    if_done_o <= 1'b1;
                    if_inst_o <= result_next;
                end else begin
                    mem_done_o  <= 1'b1;
                    mem_rdata_o <= result_next;
                end
            end
            if (last_write) begin
                mem_done_o <= 1'b1;
            end
        end
    end

endmodule
